// File: rtl/edge_level_gen.sv
// Rebuilds a level from single-cycle rise/fall request pulses, enforcing minimum
// high and low dwell times with a one-deep pending slot for early requests.
module edge_level_gen #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_i,
  input  logic fall_i,
  output logic level_o,
  output logic busy_o,
  output logic err_o
);

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    LOW_HOLD  = 2'd1,
    HIGH_IDLE = 2'd2,
    HIGH_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pend_r;
  logic             level_r;
  logic             busy_r;
  logic             err_r;

  logic both_s;
  logic rise_s;
  logic fall_s;
  logic cnt_zero_s;

  // Simultaneous requests cancel each other; only a lone request is acted on.
  assign both_s     = rise_i & fall_i;
  assign rise_s     = rise_i & ~fall_i;
  assign fall_s     = fall_i & ~rise_i;
  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  // Dwell FSM with registered level, busy and error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LOW_IDLE;
      cnt_r   <= CNT_ZERO;
      pend_r  <= 1'b0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= both_s;
      case (state_r)
        LOW_IDLE: begin
          if (rise_s) begin
            state_r <= HIGH_HOLD;
            level_r <= 1'b1;
            busy_r  <= 1'b1;
            cnt_r   <= HIGH_LOAD;
          end
          if (fall_s) err_r <= 1'b1;
        end
        HIGH_IDLE: begin
          if (fall_s) begin
            state_r <= LOW_HOLD;
            level_r <= 1'b0;
            busy_r  <= 1'b1;
            cnt_r   <= LOW_LOAD;
          end
          if (rise_s) err_r <= 1'b1;
        end
        HIGH_HOLD: begin
          if (rise_s || (fall_s && pend_r)) err_r <= 1'b1;
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (fall_s && !pend_r) pend_r <= 1'b1;
          end else if (pend_r || fall_s) begin
            // Expiry edge: a pending or same-cycle request switches with no idle gap.
            state_r <= LOW_HOLD;
            level_r <= 1'b0;
            busy_r  <= 1'b1;
            cnt_r   <= LOW_LOAD;
            pend_r  <= 1'b0;
          end else begin
            state_r <= HIGH_IDLE;
            busy_r  <= 1'b0;
          end
        end
        LOW_HOLD: begin
          if (fall_s || (rise_s && pend_r)) err_r <= 1'b1;
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (rise_s && !pend_r) pend_r <= 1'b1;
          end else if (pend_r || rise_s) begin
            state_r <= HIGH_HOLD;
            level_r <= 1'b1;
            busy_r  <= 1'b1;
            cnt_r   <= HIGH_LOAD;
            pend_r  <= 1'b0;
          end else begin
            state_r <= LOW_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= LOW_IDLE;
          cnt_r   <= CNT_ZERO;
          pend_r  <= 1'b0;
          level_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_r;
  assign busy_o  = busy_r;
  assign err_o   = err_r;

endmodule
